// File: rtl/pulp_clk_switch_pkg.sv
// Shared types and constants for the SoC clock switch sequencer.
package pulp_clk_switch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LOCK,
    ST_GATE_OFF,
    ST_SWITCH,
    ST_DONE,
    ST_FAIL
  } clk_sw_state_e;

  localparam logic CLK_SEL_CLK0 = 1'b0;
  localparam logic CLK_SEL_CLK1 = 1'b1;

  // One counter serves both the gate phases and the lock timeout.
  function automatic int cnt_width(input int gate_cycles, input int timeout_cycles);
    int m;
    m = (gate_cycles > timeout_cycles) ? gate_cycles : timeout_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pulp_clk_sync_serv.sv
// Multi-flop synchroniser for a level signal; output is the input delayed SYNC_STAGES edges.
module pulp_clk_sync_serv #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ff <= '0;
    else         ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/pulp_clk_switch_ctrl.sv
// Glitch-safe clock mux/gate sequencer: gate off, change select, gate on, acknowledge.
// Runs on the always-on reference clock and falls back to clk0 when clk1 loses lock.
module pulp_clk_switch_ctrl
  import pulp_clk_switch_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int GATE_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_valid_i,
  input  logic req_sel_i,
  output logic req_ready_o,
  output logic done_o,
  output logic err_o,
  output logic lost_o,
  input  logic clk1_lock_i,
  output logic clk_en_o,
  output logic clk_sel_o,
  output logic busy_o
);

  localparam int CW = cnt_width(GATE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] GATE_LAST = CW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

  clk_sw_state_e state, state_nxt;
  logic [CW-1:0] cnt;
  logic          target, target_nxt;
  logic          sel, sel_nxt;
  logic          from_req, from_req_nxt;
  logic          lock_s;
  logic          fb;

  pulp_clk_sync_serv #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d     (clk1_lock_i),
    .q     (lock_s)
  );

  assign fb = (sel == CLK_SEL_CLK1) && !lock_s;

  always_comb begin
    state_nxt    = state;
    target_nxt   = target;
    sel_nxt      = sel;
    from_req_nxt = from_req;
    unique case (state)
      ST_IDLE: begin
        // Fallback wins; a pending request sees ready low and keeps waiting.
        if (fb) begin
          state_nxt    = ST_GATE_OFF;
          target_nxt   = CLK_SEL_CLK0;
          from_req_nxt = 1'b0;
        end else if (req_valid_i) begin
          target_nxt   = req_sel_i;
          from_req_nxt = 1'b1;
          if (req_sel_i == sel)                          state_nxt = ST_DONE;
          else if (req_sel_i == CLK_SEL_CLK0 || lock_s)  state_nxt = ST_GATE_OFF;
          else                                           state_nxt = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s)              state_nxt = ST_GATE_OFF;
        else if (cnt == TO_LAST) state_nxt = ST_FAIL;
      end
      ST_GATE_OFF: begin
        if (cnt == GATE_LAST) begin
          state_nxt = ST_SWITCH;
          sel_nxt   = target;
        end
      end
      ST_SWITCH: begin
        if (cnt == GATE_LAST) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_FAIL: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      target   <= CLK_SEL_CLK0;
      sel      <= CLK_SEL_CLK0;
      from_req <= 1'b0;
    end else begin
      state    <= state_nxt;
      target   <= target_nxt;
      sel      <= sel_nxt;
      from_req <= from_req_nxt;
      // Counts only in the timed states, so it never runs free in IDLE.
      if (state_nxt != state)
        cnt <= '0;
      else if (state == ST_WAIT_LOCK || state == ST_GATE_OFF || state == ST_SWITCH)
        cnt <= cnt + 1'b1;
    end
  end

  assign req_ready_o = (state == ST_IDLE) && !fb;
  assign busy_o      = (state != ST_IDLE);
  assign clk_sel_o   = sel;
  assign clk_en_o    = !(state == ST_GATE_OFF || state == ST_SWITCH);
  assign done_o      = (state == ST_DONE) && from_req;
  assign err_o       = (state == ST_FAIL);
  assign lost_o      = (state == ST_GATE_OFF) && !from_req && (cnt == '0);

endmodule

// File: tb/tb_pulp_clk_switch_ctrl.sv
// Directed bench for the clock switch sequencer (G=4, SYNC=2, TIMEOUT=16).
// Inputs are driven and outputs checked on the falling edge between rising edges.
module tb_pulp_clk_switch_ctrl;

  localparam int G  = 4;
  localparam int TO = 16;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic req_valid_i = 1'b0;
  logic req_sel_i = 1'b0;
  logic clk1_lock_i = 1'b0;
  logic clk_run = 1'b1;
  logic req_ready_o, done_o, err_o, lost_o, clk_en_o, clk_sel_o, busy_o;

  int total = 0;
  int bad   = 0;

  always #5 if (clk_run) clk_i = ~clk_i;

  pulp_clk_switch_ctrl #(
    .SYNC_STAGES   (2),
    .GATE_CYCLES   (G),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid_i),
    .req_sel_i  (req_sel_i),
    .req_ready_o(req_ready_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .lost_o     (lost_o),
    .clk1_lock_i(clk1_lock_i),
    .clk_en_o   (clk_en_o),
    .clk_sel_o  (clk_sel_o),
    .busy_o     (busy_o)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Full gated switch starting from IDLE with lock already synchronised high.
  task automatic gated_switch(input logic new_sel);
    logic old_sel;
    old_sel = ~new_sel;
    req_valid_i = 1'b1;
    req_sel_i   = new_sel;
    chk("gs_ready_T", req_ready_o, 1'b1);
    tick();
    req_valid_i = 1'b0;
    chk("gs_lost_T1", lost_o, 1'b0);
    for (int k = 1; k <= 2*G; k++) begin
      if (k > 1) tick();
      chk("gs_en_low", clk_en_o, 1'b0);
      chk("gs_sel", clk_sel_o, (k > G) ? new_sel : old_sel);
      chk("gs_no_done", done_o, 1'b0);
    end
    tick();
    chk("gs_done", done_o, 1'b1);
    chk("gs_en_on", clk_en_o, 1'b1);
    chk("gs_sel_final", clk_sel_o, new_sel);
    tick();
    chk("gs_ready_after", req_ready_o, 1'b1);
    chk("gs_done_cleared", done_o, 1'b0);
    chk("gs_idle", busy_o, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state, checked while reset is held and after release
    #12;
    chk("rst_sel", clk_sel_o, 1'b0);
    chk("rst_en", clk_en_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_lost", lost_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    chk("rel_ready", req_ready_o, 1'b1);
    chk("rel_busy", busy_o, 1'b0);
    chk("rel_en", clk_en_o, 1'b1);

    // 3: request clk0 while on clk0 -> done at T+1, no gating
    req_valid_i = 1'b1;
    req_sel_i   = 1'b0;
    chk("same_ready_T", req_ready_o, 1'b1);
    tick();
    req_valid_i = 1'b0;
    chk("same_done", done_o, 1'b1);
    chk("same_en_T1", clk_en_o, 1'b1);
    chk("same_ready_T1", req_ready_o, 1'b0);
    tick();
    chk("same_done_clr", done_o, 1'b0);
    chk("same_en_T2", clk_en_o, 1'b1);
    chk("same_ready_T2", req_ready_o, 1'b1);

    // 4: lock never arrives -> err at T+17, outputs untouched
    req_valid_i = 1'b1;
    req_sel_i   = 1'b1;
    tick();
    req_valid_i = 1'b0;
    chk("to_busy_T1", busy_o, 1'b1);
    chk("to_ready_T1", req_ready_o, 1'b0);
    for (int k = 2; k <= 16; k++) begin
      tick();
      chk("to_en_wait", clk_en_o, 1'b1);
      chk("to_no_err", err_o, 1'b0);
    end
    tick();
    chk("to_err", err_o, 1'b1);
    chk("to_sel", clk_sel_o, 1'b0);
    chk("to_en", clk_en_o, 1'b1);
    chk("to_no_done", done_o, 1'b0);
    tick();
    chk("to_err_clr", err_o, 1'b0);
    chk("to_ready", req_ready_o, 1'b1);

    // 4 variant: lock raised at T+5 -> GATE_OFF from T+8, done at T+16
    req_valid_i = 1'b1;
    req_sel_i   = 1'b1;
    tick();
    req_valid_i = 1'b0;
    repeat (4) tick();
    clk1_lock_i = 1'b1;
    tick();
    tick();
    chk("wl_en_T7", clk_en_o, 1'b1);
    chk("wl_busy_T7", busy_o, 1'b1);
    tick();
    chk("wl_en_T8", clk_en_o, 1'b0);
    chk("wl_sel_T8", clk_sel_o, 1'b0);
    repeat (4) tick();
    chk("wl_sel_T12", clk_sel_o, 1'b1);
    chk("wl_en_T12", clk_en_o, 1'b0);
    repeat (4) tick();
    chk("wl_done_T16", done_o, 1'b1);
    chk("wl_en_T16", clk_en_o, 1'b1);
    tick();
    chk("wl_ready_T17", req_ready_o, 1'b1);

    // gated switch back to clk0, then 2: clk0 -> clk1
    gated_switch(1'b0);
    gated_switch(1'b1);

    // 5: lock loss on clk1 while a sel=1 request is pending
    clk1_lock_i = 1'b0;
    tick();
    chk("fb_ready_before", req_ready_o, 1'b1);
    tick();
    req_valid_i = 1'b1;
    req_sel_i   = 1'b1;
    chk("fb_ready_low", req_ready_o, 1'b0);
    chk("fb_still_idle", busy_o, 1'b0);
    tick();
    chk("fb_lost", lost_o, 1'b1);
    chk("fb_en_S1", clk_en_o, 1'b0);
    chk("fb_sel_S1", clk_sel_o, 1'b1);
    chk("fb_ready_S1", req_ready_o, 1'b0);
    for (int k = 2; k <= 2*G; k++) begin
      tick();
      chk("fb_lost_once", lost_o, 1'b0);
      chk("fb_en_low", clk_en_o, 1'b0);
      chk("fb_sel", clk_sel_o, (k > G) ? 1'b0 : 1'b1);
    end
    tick();
    chk("fb_no_done", done_o, 1'b0);
    chk("fb_en_S9", clk_en_o, 1'b1);
    chk("fb_busy_S9", busy_o, 1'b1);
    tick();
    chk("fb_ready_S10", req_ready_o, 1'b1);
    chk("fb_sel_S10", clk_sel_o, 1'b0);
    tick();
    chk("fb_waitlock_busy", busy_o, 1'b1);
    chk("fb_waitlock_ready", req_ready_o, 1'b0);
    chk("fb_waitlock_en", clk_en_o, 1'b1);
    req_valid_i = 1'b0;
    clk1_lock_i = 1'b1;
    tick();
    tick();
    chk("fb_wl_en_S13", clk_en_o, 1'b1);
    tick();
    chk("fb_go_en_S14", clk_en_o, 1'b0);
    repeat (5) tick();
    chk("fb_switch_sel", clk_sel_o, 1'b1);
    chk("fb_switch_en", clk_en_o, 1'b0);

    // 6: asynchronous reset mid-SWITCH with the clock stopped
    clk_run = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("ar_sel", clk_sel_o, 1'b0);
    chk("ar_en", clk_en_o, 1'b1);
    chk("ar_busy", busy_o, 1'b0);
    chk("ar_ready", req_ready_o, 1'b1);
    #5 rst_ni = 1'b1;
    #5 clk_run = 1'b1;
    @(negedge clk_i);
    repeat (3) tick();
    gated_switch(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulp_clk_switch_ctrl.md
Name: pulp_clk_switch_ctrl

Overview:
- Sequencer that drives the select and gate-enable of the SoC clock mux/gate pair from the always-on reference clock domain.
- Accepts switch requests over a valid/ready handshake and synchronises the alternate-clock (PLL) lock.
- Switches glitch-safely: gate off, change select, gate on, acknowledge.
- Falls back to clk0 autonomously on lock loss.

Parameters:
SYNC_STAGES, 2, flops in the lock synchroniser (>=2)
GATE_CYCLES, 4, cycles held in each of the gate-off and post-select phases (>=1)
TIMEOUT_CYCLES, 1024, max cycles waiting for lock before failing (>=1)

Ports:
clk_i  in  1  always-on reference clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  switch request valid
req_sel_i  in  1  requested source: 0=clk0, 1=clk1
req_ready_o  out  1  controller can accept a request
done_o  out  1  one-cycle pulse: requested switch completed
err_o  out  1  one-cycle pulse: lock timeout, request dropped
lost_o  out  1  one-cycle pulse: lock lost, fallback started
clk1_lock_i  in  1  asynchronous PLL lock for clk1
clk_en_o  out  1  clock-gate enable to the downstream gate
clk_sel_o  out  1  select to the clock mux
busy_o  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, immediate, including mid-sequence): state IDLE, clk_sel_o=0, clk_en_o=1, done_o=err_o=lost_o=0, counters 0, synchroniser cleared.
- All outputs are registered or a Moore decode of registered state. No input-to-output combinational path except req_ready_o.
- lock_s is clk1_lock_i delayed SYNC_STAGES clk_i edges.
- States: IDLE, WAIT_LOCK, GATE_OFF, SWITCH, DONE, FAIL.
- Fallback condition: fb = (clk_sel_o==1 && lock_s==0).
- req_ready_o = (state==IDLE) && !fb. Handshake fires on valid&&ready. The target is latched at the firing edge T.
- IDLE with fb:
  - Go to GATE_OFF with target 0.
  - lost_o pulses in the first GATE_OFF cycle.
  - The completion for this sequence asserts no done_o.
  - Fallback takes priority over a simultaneous request, which waits because ready=0.
- IDLE with handshake:
  - target == clk_sel_o: go to DONE (done_o at T+1). No gating.
  - target 0, or target 1 with lock_s=1: go to GATE_OFF.
  - target 1 with lock_s=0: go to WAIT_LOCK.
- WAIT_LOCK:
  - Counter increments each cycle.
  - lock_s=1: go to GATE_OFF on the next edge.
  - TIMEOUT_CYCLES cycles elapsed without lock: go to FAIL.
- GATE_OFF: clk_en_o=0, clk_sel_o=old. Lasts GATE_CYCLES cycles.
- SWITCH: clk_en_o=0, clk_sel_o=target. Lasts GATE_CYCLES cycles.
- DONE: clk_en_o=1 for one cycle. done_o=1 if the sequence was a request, 0 if it was a fallback. Then IDLE.
- FAIL: err_o=1 for one cycle. clk_sel_o and clk_en_o unchanged. Then IDLE.
- Request timing for a gated switch: clk_en_o low T+1..T+2G; clk_sel_o changes at T+1+G; done_o and clk_en_o=1 at T+1+2G; ready at T+2+2G.
- Once GATE_OFF is entered the sequence always completes. Lock loss during it is handled by the fb check back in IDLE.
- Lock toggling during WAIT_LOCK: only the lock_s value at each edge matters. No debounce.
- Counters are sized $clog2(max(GATE_CYCLES,TIMEOUT_CYCLES)+1) and clear on every state entry. No wrap occurs.
- req_valid_i is ignored outside IDLE. A requester holds valid until ready.

Decomposition:
- Package pulp_clk_switch_pkg: state enum (clk_sw_state_e), CLK_SEL_CLK0/CLK_SEL_CLK1 constants.
- Sub-module pulp_clk_sync_serv: SYNC_STAGES-deep flop synchroniser, clk_i/rst_ni, reset to 0.
- FSM, counters and output registers live in the top module.

Test Plan:
Parameters for all scenarios: G=4, SYNC=2, TIMEOUT=16.
1. Assert rst_ni=0 then release -> clk_sel_o=0, clk_en_o=1, req_ready_o=1, busy_o=0, all pulses 0.
2. Lock high >=2 cycles, request sel=1 accepted at T -> clk_en_o=0 T+1..T+8, clk_sel_o=1 from T+5, done_o=1 and clk_en_o=1 at T+9, ready at T+10.
3. Request sel=0 while already on clk0 -> done_o at T+1, clk_en_o never drops, ready at T+2.
4. Lock low, request sel=1 -> err_o pulse at T+17, clk_sel_o=0, clk_en_o=1 throughout. Variant: raise lock at T+5 -> lock_s at T+7, GATE_OFF from T+8, done_o at T+16.
5. On clk1, drop lock at cycle X while req_valid_i=1 sel=1 -> ready=0 once lock_s=0, lost_o one cycle, clk_sel_o=0 after 4 gated cycles, no done_o, then the request is accepted and waits in WAIT_LOCK.
6. Pull rst_ni low mid-SWITCH with clk_i stopped -> clk_sel_o=0, clk_en_o=1, busy_o=0 immediately. After release, a request sel=1 sequences normally from IDLE.
